mem_port_arbiter: RTL and testbench

//  Arbitrates the single shared memory port between instruction fetch and load/store data access.

---
 rtl/mem_port_arbiter.sv | 124 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Shared memory port arbiter between instruction fetch and data access.
// Data wins ties; a saturating counter forces fetch through after a run of data grants.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_ack,
  output logic [DATA_WIDTH-1:0] if_rdata,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic                  d_ack,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  pc_stall,
  output logic                  busy
);

  localparam int CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IF_WAIT = 2'd1,
    D_WAIT  = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] starve_cnt_q, starve_cnt_d;
  logic          we_q, we_d;

  logic idle;
  logic grant_if;
  logic grant_d;
  logic starved;

  // Grant decision: only in IDLE, and never while reset is held so a
  // pending store cannot reach the memory during reset.
  always_comb begin
    idle     = (state_q == IDLE) & ~reset;
    starved  = (starve_cnt_q == LIMIT);
    grant_if = idle & if_req & (~d_req | starved);
    grant_d  = idle & d_req & ~grant_if;
  end

  // State, starvation counter and store flag registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      starve_cnt_q <= '0;
      we_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      we_q         <= we_d;
    end
  end

  // Next-state, counter update and memory-side outputs.
  always_comb begin
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    we_d         = we_q;
    mem_addr     = '0;
    mem_we       = 1'b0;
    mem_wdata    = '0;
    if_ack       = 1'b0;
    if_rdata     = '0;
    d_ack        = 1'b0;
    d_rdata      = '0;
    busy         = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (grant_if) begin
          mem_addr     = if_addr;
          starve_cnt_d = '0;
          state_d      = IF_WAIT;
        end else if (grant_d) begin
          mem_addr  = d_addr;
          mem_wdata = d_wdata;
          mem_we    = d_we;
          we_d      = d_we;
          state_d   = D_WAIT;
          if (if_req && !starved) begin
            starve_cnt_d = starve_cnt_q + CW'(1);
          end
        end
        if (!if_req) begin
          starve_cnt_d = '0;
        end
      end
      IF_WAIT: begin
        busy     = 1'b1;
        if_ack   = 1'b1;
        if_rdata = mem_rdata;
        state_d  = IDLE;
      end
      D_WAIT: begin
        busy    = 1'b1;
        d_ack   = 1'b1;
        d_rdata = we_q ? '0 : mem_rdata;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // The PC holds from the first request cycle up to, not including, the ack.
  always_comb begin
    pc_stall = if_req & ~if_ack;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a synchronous-read memory model.
// Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ack;
  logic [31:0] if_rdata;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic [31:0] mem_addr;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        pc_stall;
  logic        busy;

  int checks = 0;
  int passed = 0;

  logic [31:0] mem [256];

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_WIDTH  (32),
    .DATA_WIDTH  (32),
    .STARVE_LIMIT(2)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_ack   (if_ack),
    .if_rdata (if_rdata),
    .d_req    (d_req),
    .d_we     (d_we),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_ack    (d_ack),
    .d_rdata  (d_rdata),
    .mem_addr (mem_addr),
    .mem_we   (mem_we),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .pc_stall (pc_stall),
    .busy     (busy)
  );

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr[9:2]] <= mem_wdata;
    mem_rdata <= mem[mem_addr[9:2]];
  end

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[4] = 32'h20080005;
    mem[65] = 32'h11110104;
    mem[66] = 32'h22220108;
    mem[67] = 32'h3333010C;
    reset = 1'b1;
    if_req = 0; if_addr = 0;
    d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
    #1;
    smp();
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_acks", {if_ack, d_ack}, 0);
    chk("rst_busy", busy, 0);
    nxt();
    reset = 1'b0;

    // 1 fetch only
    if_req = 1; if_addr = 32'h10;
    smp();
    chk("t1_c0_addr", mem_addr, 32'h10);
    chk("t1_c0_stall", pc_stall, 1);
    chk("t1_c0_we", mem_we, 0);
    nxt(); smp();
    chk("t1_c1_ack", if_ack, 1);
    chk("t1_c1_rdata", if_rdata, 32'h20080005);
    chk("t1_c1_stall", pc_stall, 0);
    chk("t1_c1_busy", busy, 1);
    nxt();
    if_req = 0;

    // 2 store, then load back
    d_req = 1; d_we = 1; d_addr = 32'h100; d_wdata = 32'hDEADBEEF;
    smp();
    chk("t2_c0_we", mem_we, 1);
    chk("t2_c0_addr", mem_addr, 32'h100);
    chk("t2_c0_wdata", mem_wdata, 32'hDEADBEEF);
    nxt(); smp();
    chk("t2_c1_ack", d_ack, 1);
    chk("t2_c1_rdata", d_rdata, 0);
    chk("t2_c1_we", mem_we, 0);
    nxt();
    d_we = 0; d_wdata = 0;
    smp();
    chk("t2_ld_we", mem_we, 0);
    nxt(); smp();
    chk("t2_ld_rdata", d_rdata, 32'hDEADBEEF);
    nxt();
    d_req = 0;

    // 3 tie: data first, then fetch
    if_req = 1; if_addr = 32'h10;
    d_req = 1; d_we = 0; d_addr = 32'h100;
    smp();
    chk("t3_c0_addr", mem_addr, 32'h100);
    chk("t3_c0_stall", pc_stall, 1);
    nxt(); smp();
    chk("t3_c1_ack", {if_ack, d_ack}, 2'b01);
    chk("t3_c1_rdata", d_rdata, 32'hDEADBEEF);
    nxt();
    d_req = 0;
    smp();
    chk("t3_c2_addr", mem_addr, 32'h10);
    nxt(); smp();
    chk("t3_c3_ack", {if_ack, d_ack}, 2'b10);
    chk("t3_c3_rdata", if_rdata, 32'h20080005);
    nxt();
    if_req = 0;

    // 4 starvation: D, D, F
    if_req = 1; if_addr = 32'h10;
    d_req = 1; d_we = 0; d_addr = 32'h104;
    smp();
    chk("t4_c0_addr", mem_addr, 32'h104);
    nxt(); smp();
    chk("t4_c1_dack", d_ack, 1);
    chk("t4_c1_rdata", d_rdata, 32'h11110104);
    nxt();
    d_addr = 32'h108;
    smp();
    chk("t4_c2_addr", mem_addr, 32'h108);
    nxt(); smp();
    chk("t4_c3_dack", d_ack, 1);
    chk("t4_cnt_sat", dut.starve_cnt_q, 2);
    nxt();
    d_addr = 32'h10C;
    smp();
    chk("t4_c4_addr", mem_addr, 32'h10);
    nxt(); smp();
    chk("t4_c5_ack", {if_ack, d_ack}, 2'b10);
    chk("t4_c5_rdata", if_rdata, 32'h20080005);
    nxt();
    if_req = 0;
    smp();
    chk("t4_c6_addr", mem_addr, 32'h10C);
    nxt(); smp();
    chk("t4_c7_rdata", d_rdata, 32'h3333010C);
    nxt();
    d_req = 0;

    // 5 reset during D_WAIT of a load
    d_req = 1; d_we = 0; d_addr = 32'h100;
    smp();
    chk("t5_c0_addr", mem_addr, 32'h100);
    nxt();
    reset = 1;
    smp();
    chk("t5_rst_dack", d_ack, 0);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_we", mem_we, 0);
    nxt();
    reset = 0;
    smp();
    chk("t5_reissue", mem_addr, 32'h100);
    nxt(); smp();
    chk("t5_ack", d_ack, 1);
    chk("t5_rdata", d_rdata, 32'hDEADBEEF);
    nxt();
    d_req = 0;

    // 6 idle
    for (int i = 0; i < 5; i++) begin
      smp();
      chk("t6_we", mem_we, 0);
      chk("t6_addr", mem_addr, 0);
      chk("t6_acks", {if_ack, d_ack}, 0);
      chk("t6_cnt", dut.starve_cnt_q, 0);
      nxt();
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
